// File: rtl/hpc3_rand_feeder.sv
// Mask-bit source for HPC3 masked AND gadgets: a bank of 32-bit Galois LFSR lanes,
// seeded beat by beat, warmed up, then stepped once per accepted output word.
module hpc3_rand_feeder #(
    parameter int unsigned security_order = 1,
    parameter int unsigned num_gadgets    = 1,
    parameter int unsigned warmup_cycles  = 32
) (
    input  logic                                                     clk,
    input  logic                                                     rst_n,
    input  logic [31:0]                                              seed_in,
    input  logic                                                     seed_valid,
    output logic                                                     seed_ready,
    output logic [num_gadgets*security_order*(security_order+1)-1:0] rnd_o,
    output logic                                                     rnd_valid,
    input  logic                                                     rnd_ready
);

    localparam int unsigned RW   = num_gadgets * security_order * (security_order + 1);
    localparam int unsigned NL   = (RW + 31) / 32;
    localparam int unsigned IdxW = (NL > 1) ? $clog2(NL) : 1;
    localparam int unsigned WcW  = (warmup_cycles > 1) ? $clog2(warmup_cycles) : 1;

    localparam logic [31:0]     Taps    = 32'h8020_0003;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NL - 1);
    localparam logic [WcW-1:0]  LastWc  = WcW'(warmup_cycles - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWarmup,
        StRun
    } state_e;

    localparam state_e PostLoadSt = (warmup_cycles > 0) ? StWarmup : StRun;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form.
    function automatic logic [31:0] lane_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? Taps : 32'h0);
    endfunction

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [WcW-1:0]  wcnt_q, wcnt_d;
    logic [31:0]     lane_q [NL];
    logic [31:0]     lane_d [NL];
    logic [31:0]     seed_word;
    logic [NL*32-1:0] lanes_flat;

    // An all-zero lane would lock up, so a zero beat is replaced by 1.
    assign seed_word = (seed_in == 32'h0) ? 32'h1 : seed_in;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wcnt_d     = wcnt_q;
        for (int i = 0; i < int'(NL); i++) begin
            lane_d[i] = lane_q[i];
        end
        seed_ready = (state_q != StWarmup);
        rnd_valid  = (state_q == StRun);

        case (state_q)
            StIdle, StRun: begin
                // A seed beat in RUN wins over a simultaneous consumer handshake.
                if (seed_valid) begin
                    lane_d[0] = seed_word;
                    idx_d     = IdxW'(1);
                    state_d   = (NL == 1) ? PostLoadSt : StLoad;
                end else if (state_q == StRun && rnd_ready) begin
                    for (int i = 0; i < int'(NL); i++) begin
                        lane_d[i] = lane_step(lane_q[i]);
                    end
                end
            end
            StLoad: begin
                if (seed_valid) begin
                    lane_d[idx_q] = seed_word;
                    idx_d         = idx_q + IdxW'(1);
                    if (idx_q == LastIdx) begin
                        state_d = PostLoadSt;
                    end
                end
            end
            StWarmup: begin
                for (int i = 0; i < int'(NL); i++) begin
                    lane_d[i] = lane_step(lane_q[i]);
                end
                if (wcnt_q == LastWc) begin
                    wcnt_d  = '0;
                    state_d = StRun;
                end else begin
                    wcnt_d = wcnt_q + WcW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        lanes_flat = '0;
        for (int i = 0; i < int'(NL); i++) begin
            lanes_flat[i*32 +: 32] = lane_q[i];
        end
    end

    assign rnd_o = lanes_flat[RW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            wcnt_q  <= '0;
            for (int i = 0; i < int'(NL); i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            for (int i = 0; i < int'(NL); i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

endmodule

// File: tb/tb_hpc3_rand_feeder.sv
// Scoreboarded bench for hpc3_rand_feeder: three configurations share one reset, expected
// words are queued by the stimulus and popped by per-instance monitors on each handshake.
module tb_hpc3_rand_feeder;

    logic clk;
    logic rst_n;

    // A: d=1, 1 gadget, no warm-up.  B: d=3, 4 gadgets (two lanes).  C: d=1, warm-up 2.
    logic [31:0] sa_in, sb_in, sc_in;
    logic        sa_v, sb_v, sc_v;
    logic        sa_r, sb_r, sc_r;
    logic [1:0]  ra_o;
    logic [47:0] rb_o;
    logic [1:0]  rc_o;
    logic        ra_v, rb_v, rc_v;
    logic        ra_rdy, rb_rdy, rc_rdy;

    int n_vec;
    int n_err;

    logic [1:0]  qa [$];
    logic [47:0] qb [$];
    logic [1:0]  qc [$];
    logic [1:0]  ea, ec;
    logic [47:0] eb;
    logic [31:0] mc;

    hpc3_rand_feeder #(.security_order(1), .num_gadgets(1), .warmup_cycles(0)) u_a (
        .clk(clk), .rst_n(rst_n), .seed_in(sa_in), .seed_valid(sa_v), .seed_ready(sa_r),
        .rnd_o(ra_o), .rnd_valid(ra_v), .rnd_ready(ra_rdy)
    );

    hpc3_rand_feeder #(.security_order(3), .num_gadgets(4), .warmup_cycles(0)) u_b (
        .clk(clk), .rst_n(rst_n), .seed_in(sb_in), .seed_valid(sb_v), .seed_ready(sb_r),
        .rnd_o(rb_o), .rnd_valid(rb_v), .rnd_ready(rb_rdy)
    );

    hpc3_rand_feeder #(.security_order(1), .num_gadgets(1), .warmup_cycles(2)) u_c (
        .clk(clk), .rst_n(rst_n), .seed_in(sc_in), .seed_valid(sc_v), .seed_ready(sc_r),
        .rnd_o(rc_o), .rnd_valid(rc_v), .rnd_ready(rc_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lstep(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic extra(input string nm, input logic [63:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got word %h with no expected word queued", nm, act);
    endtask

    // A word counts as consumed only on a handshake not overridden by a reseed.
    always @(negedge clk) begin
        if (rst_n && ra_v && ra_rdy && !(sa_v && sa_r)) begin
            if (qa.size() == 0) extra("a_extra", 64'(ra_o));
            else begin
                ea = qa.pop_front();
                chk("a_rnd", 64'(ra_o), 64'(ea));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rb_v && rb_rdy && !(sb_v && sb_r)) begin
            if (qb.size() == 0) extra("b_extra", 64'(rb_o));
            else begin
                eb = qb.pop_front();
                chk("b_rnd", 64'(rb_o), 64'(eb));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rc_v && rc_rdy && !(sc_v && sc_r)) begin
            if (qc.size() == 0) extra("c_extra", 64'(rc_o));
            else begin
                ec = qc.pop_front();
                chk("c_rnd", 64'(rc_o), 64'(ec));
            end
        end
    end

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        sa_in  = '0; sb_in = '0; sc_in = '0;
        sa_v   = 1'b0; sb_v = 1'b0; sc_v = 1'b0;
        ra_rdy = 1'b0; rb_rdy = 1'b0; rc_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle with no seed: quiet outputs, seed_ready high.
        repeat (100) begin
            @(negedge clk);
            chk("idle_quiet", {ra_v, rb_v, rc_v, sa_r, sb_r, sc_r, |ra_o, |rb_o, |rc_o},
                9'b000_111_000);
        end

        // A: seed 1, four words 01,11,10,01 (lanes 1, 80200003, C0300002, 60180001).
        @(posedge clk);
        #1;
        ra_rdy = 1'b1; sa_in = 32'h1; sa_v = 1'b1;
        qa.push_back(2'b01); qa.push_back(2'b11); qa.push_back(2'b10); qa.push_back(2'b01);
        @(posedge clk);
        #1 sa_v = 1'b0;
        repeat (4) @(posedge clk);
        #1 ra_rdy = 1'b0;
        // Backpressure: lane is B02C0003, must hold.
        repeat (5) begin
            @(negedge clk);
            chk("a_hold_valid", 64'(ra_v), 64'd1);
            chk("a_hold_rnd", 64'(ra_o), 64'd3);
        end
        qa.push_back(2'b11);
        @(posedge clk);
        #1 ra_rdy = 1'b1;
        @(posedge clk);
        #1 ra_rdy = 1'b0;
        @(negedge clk);
        chk("a_one_step", 64'(ra_o), 64'd2);  // D8360002

        // B: zero beat then 12345678; lane0 forced to 1.
        @(posedge clk);
        #1;
        rb_rdy = 1'b1; sb_in = 32'h0; sb_v = 1'b1;
        qb.push_back(48'h5678_0000_0001);
        qb.push_back(48'h2B3C_8020_0003);
        qb.push_back(48'h159E_C030_0002);
        @(posedge clk);
        #1 sb_in = 32'h1234_5678;
        @(negedge clk);
        chk("b_ready_in_load", 64'(sb_r), 64'd1);
        chk("b_valid_in_load", 64'(rb_v), 64'd0);
        @(posedge clk);
        #1 sb_v = 1'b0;
        repeat (3) @(posedge clk);
        #1 rb_rdy = 1'b0;

        // B: reseed in RUN with rnd_ready=1 in the same cycle; no step may occur.
        @(posedge clk);
        #1;
        rb_rdy = 1'b1; sb_in = 32'hA5A5_A5A5; sb_v = 1'b1;
        @(negedge clk);
        chk("b_pre_reseed", 64'(rb_o), 64'h8ACF_6018_0001);
        @(posedge clk);
        #1 sb_in = 32'h0F0F_0F0F;
        @(negedge clk);
        chk("b_reseed_valid", 64'(rb_v), 64'd0);
        chk("b_reseed_sready", 64'(sb_r), 64'd1);
        chk("b_no_step", 64'(rb_o), 64'h8ACF_A5A5_A5A5);
        qb.push_back(48'h0F0F_A5A5_A5A5);
        @(posedge clk);
        #1 sb_v = 1'b0;
        @(posedge clk);
        #1 rb_rdy = 1'b0;

        // C: warm-up 2, valid rises in the third cycle after the seed edge.
        @(posedge clk);
        #1;
        sc_in = 32'h1; sc_v = 1'b1;
        @(posedge clk);
        #1 sc_v = 1'b0;
        @(negedge clk);
        chk("c_warm1_valid", 64'(rc_v), 64'd0);
        chk("c_warm1_sready", 64'(sc_r), 64'd0);
        @(negedge clk);
        chk("c_warm2_valid", 64'(rc_v), 64'd0);
        @(negedge clk);
        chk("c_first_valid", 64'(rc_v), 64'd1);
        chk("c_first_rnd", 64'(rc_o), 64'd2);  // C0300002

        // C: reseed with rnd_ready=1 in the same cycle, then three words.
        @(posedge clk);
        #1;
        rc_rdy = 1'b1; sc_in = 32'hDEAD_BEEF; sc_v = 1'b1;
        mc = lstep(lstep(32'hDEAD_BEEF));
        for (int i = 0; i < 3; i++) begin
            qc.push_back(mc[1:0]);
            mc = lstep(mc);
        end
        @(posedge clk);
        #1 sc_v = 1'b0;
        @(negedge clk);
        chk("c_reseed_valid", 64'(rc_v), 64'd0);
        chk("c_reseed_load", 64'(rc_o), 64'd3);
        repeat (5) @(posedge clk);
        #1 rc_rdy = 1'b0;

        // Asynchronous reset mid-cycle must clear outputs at once.
        @(negedge clk);
        chk("pre_rst_b_valid", 64'(rb_v), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {ra_v, rb_v, rc_v, sa_r, sb_r, sc_r, |ra_o, |rb_o, |rc_o},
            9'b000_111_000);

        chk("a_q_drained", 64'(qa.size()), 64'd0);
        chk("b_q_drained", 64'(qb.size()), 64'd0);
        chk("c_q_drained", 64'(qc.size()), 64'd0);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hpc3_rand_feeder.md
Name: hpc3_rand_feeder

Overview:
- Randomness source directly upstream of the HPC3 masked AND gadgets. It expands a 32-bit-per-beat seed into fresh mask bits every cycle.
- Drives the gadgets' `r` inputs: `security_order*(security_order+1)` bits per gadget, for `num_gadgets` gadgets in parallel.
- Uses a bank of 32-bit Galois LFSR lanes, with a seed-load / warm-up / run FSM and a valid/ready output handshake.

Parameters:
- security_order, 1, masking order d; each gadget needs d*(d+1) random bits (2*half_rnd).
- num_gadgets, 1, number of gadgets fed in parallel.
- warmup_cycles, 32, LFSR steps after seeding before the first valid output; 0 is legal.
- Derived: RW = num_gadgets*security_order*(security_order+1); NL = ceil(RW/32).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seed_in  input  32  seed beat.
- seed_valid  input  1  seed beat present.
- seed_ready  output  1  seed beat accepted when seed_valid & seed_ready.
- rnd_o  output  RW  random bits; slice [g*2*half_rnd +: 2*half_rnd] feeds gadget g's `r`.
- rnd_valid  output  1  rnd_o holds fresh bits.
- rnd_ready  input  1  consumer takes rnd_o this cycle.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - On rst_n=0: all lane states = 0, FSM = IDLE, load index = 0, warm-up counter = 0.
  - Outputs during reset: rnd_o = 0, rnd_valid = 0, seed_ready = 1.
  - Reset mid-operation discards all seed and state; no output until a full reseed.
- Lane step (combinational next state of a 32-bit lane s): s' = (s >> 1) ^ (s[0] ? 32'h80200003 : 0).
  - This is polynomial x^32+x^22+x^2+x+1, maximal length.
- rnd_o is the concatenation {lane NL-1, ..., lane 0} truncated to its RW LSBs, taken straight from registers (glitch-free).
- FSM states:
  - IDLE: rnd_valid = 0, seed_ready = 1. An accepted beat loads lane 0 with seed_in, sets index = 1, and moves to LOAD. If NL = 1, it goes straight to WARMUP (warmup_cycles > 0) or RUN.
  - LOAD: an accepted beat loads lane[index] and increments index. The beat that loads lane NL-1 moves to WARMUP (warmup_cycles > 0) else RUN. No accepted beat means hold.
  - WARMUP: seed_ready = 0, rnd_valid = 0. All lanes step every cycle; the counter runs 0..warmup_cycles-1. After exactly warmup_cycles steps, move to RUN.
  - RUN: rnd_valid = 1, seed_ready = 1.
    - If rnd_valid & rnd_ready, all lanes step at that edge.
    - If rnd_ready = 0, rnd_o holds stable.
    - An accepted seed beat aborts RUN: it loads lane 0 and moves to LOAD (or WARMUP/RUN if NL = 1). rnd_valid is 0 from the next cycle.
    - A seed beat and rnd_ready in the same cycle: the seed wins and no step occurs.
- Zero-seed guard: a beat of 32'h0 loads 32'h00000001 instead, so no lane is ever stuck at zero.
- Latency:
  - The first rnd_valid=1 cycle is warmup_cycles+1 cycles after the edge that loads the last lane.
  - The first output equals the seed stepped warmup_cycles times.
- Throughput: one fresh RW-bit word per cycle while rnd_ready = 1.
- No output word is ever presented valid twice: each handshake advances state.

Test Plan:
- Reset, then no seed for 100 cycles -> rnd_valid = 0, rnd_o = 0, seed_ready = 1 throughout. Assert rst_n low asynchronously mid-clock -> outputs clear immediately.
- d=1, num_gadgets=1, warmup=0, seed 32'h00000001, rnd_ready=1 -> rnd_o[1:0] sequence from lanes 0x00000001, 0x80200003, 0xC0300002, i.e. 2'b01, 2'b11, 2'b10.
- Same setup, warmup=2 -> rnd_valid rises 3 cycles after the seed edge; first lane value 0xC0300002.
- Backpressure: in RUN, hold rnd_ready=0 for 5 cycles -> rnd_o constant, rnd_valid = 1. The next handshake advances exactly one step.
- d=3, num_gadgets=4 (RW=48, NL=2), warmup=0, seeds 0x00000000 then 0x12345678 -> lane0 = 1, lane1 = 0x12345678, first rnd_o = {0x5678, 0x00000001}. seed_ready = 0 never asserted in LOAD.
- Reseed in RUN with rnd_ready=1 in the same cycle -> no step, rnd_valid = 0 the next cycle, new sequence starts from the new seed.
